// File: rtl/tdm_demultiplexer_pkg.sv
// Shared types and constants for the 4:1 TDM receive path.
package tdm_demultiplexer_pkg;

   typedef enum logic {
      HUNT = 1'b0,
      LOCK = 1'b1
   } tdm_state_t;

   localparam logic [1:0] SLOT_A = 2'd0;
   localparam logic [1:0] SLOT_B = 2'd1;
   localparam logic [1:0] SLOT_C = 2'd2;
   localparam logic [1:0] SLOT_D = 2'd3;

endpackage

// File: rtl/tdm_demultiplexer_slot_tracker.sv
// Frame alignment FSM, slot counter and mid-frame idle timeout.
//
// state | meaning
// HUNT  | waiting for a beat flagged with frame_sync
// LOCK  | aligned; slot tracks the next expected beat position
module tdm_demultiplexer_slot_tracker
   import tdm_demultiplexer_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic       frame_sync,
   output logic       store_en,
   output logic [1:0] store_idx,
   output logic       frame_done,
   output logic       sync_err,
   output logic       locked,
   output logic [1:0] slot
);

   localparam int         CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit         TO_EN = (TIMEOUT > 0);
   localparam logic [CW-1:0] TMAX  = CW'((TIMEOUT > 0) ? TIMEOUT : 0);
   localparam logic [CW-1:0] TLAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   tdm_state_t    state_q, state_d;
   logic [1:0]    slot_q, slot_d;
   logic [CW-1:0] idle_q, idle_d;
   logic          err_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= HUNT;
         slot_q   <= SLOT_A;
         idle_q   <= '0;
         sync_err <= 1'b0;
      end else begin
         state_q  <= state_d;
         slot_q   <= slot_d;
         idle_q   <= idle_d;
         sync_err <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      slot_d     = slot_q;
      idle_d     = idle_q;
      err_d      = 1'b0;
      store_en   = 1'b0;
      store_idx  = slot_q;
      frame_done = 1'b0;
      case (state_q)
         HUNT: begin
            idle_d = '0;
            if (in_valid && frame_sync) begin
               store_en  = 1'b1;
               store_idx = SLOT_A;
               slot_d    = SLOT_B;
               state_d   = LOCK;
            end
         end
         LOCK: begin
            if (in_valid) begin
               idle_d = '0;
               if (slot_q != SLOT_A && frame_sync) begin
                  err_d     = 1'b1;
                  store_en  = 1'b1;
                  store_idx = SLOT_A;
                  slot_d    = SLOT_B;
               end else if (slot_q == SLOT_A && !frame_sync) begin
                  err_d   = 1'b1;
                  slot_d  = SLOT_A;
                  state_d = HUNT;
               end else begin
                  store_en   = 1'b1;
                  slot_d     = slot_q + 2'd1;
                  frame_done = (slot_q == SLOT_D);
               end
            end else if (TO_EN && slot_q != SLOT_A) begin
               // The TIMEOUT-th consecutive idle cycle aborts the partial frame.
               if (idle_q == TLAST) begin
                  err_d   = 1'b1;
                  slot_d  = SLOT_A;
                  state_d = HUNT;
                  idle_d  = '0;
               end else if (idle_q < TMAX) begin
                  idle_d = idle_q + CW'(1);
               end
            end else begin
               idle_d = '0;
            end
         end
         default: begin
            state_d = HUNT;
            slot_d  = SLOT_A;
            idle_d  = '0;
         end
      endcase
   end

   assign locked = (state_q == LOCK);
   assign slot   = slot_q;

endmodule

// File: rtl/tdm_demultiplexer.sv
// 4:1 TDM receiver: reassembles slot beats into a registered four-channel frame.
module tdm_demultiplexer
   import tdm_demultiplexer_pkg::*;
#(
   parameter int W       = 4,
   parameter int TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   input  logic         frame_sync,
   output logic [W-1:0] a_out,
   output logic [W-1:0] b_out,
   output logic [W-1:0] c_out,
   output logic [W-1:0] d_out,
   output logic         frame_valid,
   output logic         locked,
   output logic [1:0]   slot,
   output logic         sync_err
);

   logic         store_en;
   logic [1:0]   store_idx;
   logic         frame_done;
   logic [W-1:0] shadow [0:2];

   tdm_demultiplexer_slot_tracker #(.TIMEOUT(TIMEOUT)) u_tracker (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .frame_sync (frame_sync),
      .store_en   (store_en),
      .store_idx  (store_idx),
      .frame_done (frame_done),
      .sync_err   (sync_err),
      .locked     (locked),
      .slot       (slot)
   );

   // Slot d is never shadowed: it goes straight to d_out on frame completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) shadow[i] <= '0;
      end else if (store_en && store_idx != SLOT_D) begin
         shadow[store_idx] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_out       <= '0;
         b_out       <= '0;
         c_out       <= '0;
         d_out       <= '0;
         frame_valid <= 1'b0;
      end else begin
         frame_valid <= frame_done;
         if (frame_done) begin
            a_out <= shadow[0];
            b_out <= shadow[1];
            c_out <= shadow[2];
            d_out <= in_data;
         end
      end
   end

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Directed self-checking bench for tdm_demultiplexer (W = 4, TIMEOUT = 16).
module tb_tdm_demultiplexer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [3:0] in_data = 4'h0;
   logic       frame_sync = 1'b0;
   logic [3:0] a_out, b_out, c_out, d_out;
   logic       frame_valid, locked, sync_err;
   logic [1:0] slot;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   tdm_demultiplexer #(.W(4), .TIMEOUT(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .frame_sync  (frame_sync),
      .a_out       (a_out),
      .b_out       (b_out),
      .c_out       (c_out),
      .d_out       (d_out),
      .frame_valid (frame_valid),
      .locked      (locked),
      .slot        (slot),
      .sync_err    (sync_err)
   );

   // One clock with the given inputs; returns 1 ns after the edge.
   task automatic step(input logic v, input logic s, input logic [3:0] d);
      in_valid   = v;
      frame_sync = s;
      in_data    = d;
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      frame_sync = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(1'b0, 1'b0, 4'h0);
      step(1'b0, 1'b0, 4'h0);
      n_cmp++;
      if ({a_out, b_out, c_out, d_out} !== 16'h0000) begin
         n_err++; $display("FAIL reset_outs: got %h want 0000", {a_out, b_out, c_out, d_out});
      end
      n_cmp++;
      if ({frame_valid, sync_err, locked, slot} !== 5'b0) begin
         n_err++; $display("FAIL reset_flags: fv/err/lock/slot got %b want 00000",
                           {frame_valid, sync_err, locked, slot});
      end
      rst = 1'b0;
   endtask

   task automatic test_basic_frame();
      step(1'b1, 1'b1, 4'h1);
      n_cmp++;
      if ({locked, slot, frame_valid} !== 4'b1010) begin
         n_err++; $display("FAIL basic_first_beat: lock/slot/fv got %b want 1010",
                           {locked, slot, frame_valid});
      end
      step(1'b1, 1'b0, 4'h2);
      step(1'b1, 1'b0, 4'h3);
      step(1'b1, 1'b0, 4'h4);
      n_cmp++;
      if ({a_out, b_out, c_out, d_out} !== 16'h1234) begin
         n_err++; $display("FAIL basic_outs: got %h want 1234", {a_out, b_out, c_out, d_out});
      end
      n_cmp++;
      if ({frame_valid, locked, slot, sync_err} !== 5'b11000) begin
         n_err++; $display("FAIL basic_flags: fv/lock/slot/err got %b want 11000",
                           {frame_valid, locked, slot, sync_err});
      end
      step(1'b0, 1'b0, 4'h0);
      n_cmp++;
      if (frame_valid !== 1'b0 || {a_out, b_out, c_out, d_out} !== 16'h1234) begin
         n_err++; $display("FAIL basic_pulse_hold: fv %b outs %h want 0 1234",
                           frame_valid, {a_out, b_out, c_out, d_out});
      end
   endtask

   task automatic test_resync();
      step(1'b1, 1'b1, 4'hA);
      step(1'b1, 1'b0, 4'hB);
      step(1'b1, 1'b1, 4'h7);
      n_cmp++;
      if ({sync_err, locked, slot} !== 4'b1101) begin
         n_err++; $display("FAIL resync_err: err/lock/slot got %b want 1101",
                           {sync_err, locked, slot});
      end
      step(1'b1, 1'b0, 4'h8);
      n_cmp++;
      if (sync_err !== 1'b0 || {a_out, b_out, c_out, d_out} !== 16'h1234) begin
         n_err++; $display("FAIL resync_pulse: err %b outs %h want 0 1234",
                           sync_err, {a_out, b_out, c_out, d_out});
      end
      step(1'b1, 1'b0, 4'h9);
      step(1'b1, 1'b0, 4'hA);
      n_cmp++;
      if (frame_valid !== 1'b1 || {a_out, b_out, c_out, d_out} !== 16'h789A) begin
         n_err++; $display("FAIL resync_outs: fv %b outs %h want 1 789a",
                           frame_valid, {a_out, b_out, c_out, d_out});
      end
   endtask

   task automatic test_slot0_no_sync();
      step(1'b1, 1'b0, 4'h5);
      n_cmp++;
      if ({sync_err, locked, slot, frame_valid} !== 5'b10000) begin
         n_err++; $display("FAIL slot0_nosync_flags: err/lock/slot/fv got %b want 10000",
                           {sync_err, locked, slot, frame_valid});
      end
      n_cmp++;
      if ({a_out, b_out, c_out, d_out} !== 16'h789A) begin
         n_err++; $display("FAIL slot0_nosync_outs: got %h want 789a", {a_out, b_out, c_out, d_out});
      end
   endtask

   task automatic test_hunt_drop();
      step(1'b1, 1'b0, 4'h5);
      n_cmp++;
      if ({sync_err, locked, slot} !== 4'b0000) begin
         n_err++; $display("FAIL hunt_drop_5: err/lock/slot got %b want 0000", {sync_err, locked, slot});
      end
      step(1'b1, 1'b0, 4'h6);
      n_cmp++;
      if ({sync_err, locked, frame_valid} !== 3'b000 || {a_out, b_out, c_out, d_out} !== 16'h789A) begin
         n_err++; $display("FAIL hunt_drop_6: err/lock/fv %b outs %h want 000 789a",
                           {sync_err, locked, frame_valid}, {a_out, b_out, c_out, d_out});
      end
   endtask

   task automatic test_timeout();
      step(1'b1, 1'b1, 4'h1);
      step(1'b1, 1'b0, 4'h2);
      for (int i = 1; i <= 15; i++) begin
         step(1'b0, 1'b0, 4'h0);
         n_cmp++;
         if (sync_err !== 1'b0 || locked !== 1'b1) begin
            n_err++; $display("FAIL timeout_early idle %0d: err %b lock %b want 0 1", i, sync_err, locked);
         end
      end
      step(1'b0, 1'b0, 4'h0);
      n_cmp++;
      if ({sync_err, locked, slot} !== 4'b1000) begin
         n_err++; $display("FAIL timeout_fire: err/lock/slot got %b want 1000", {sync_err, locked, slot});
      end
      step(1'b0, 1'b0, 4'h0);
      n_cmp++;
      if (sync_err !== 1'b0) begin
         n_err++; $display("FAIL timeout_pulse: err %b want 0", sync_err);
      end
      // 15 idles then a beat: the frame must survive.
      step(1'b1, 1'b1, 4'h1);
      step(1'b1, 1'b0, 4'h2);
      for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 4'h0);
      step(1'b1, 1'b0, 4'h3);
      n_cmp++;
      if ({sync_err, locked, slot} !== 4'b0111) begin
         n_err++; $display("FAIL timeout_15_beat: err/lock/slot got %b want 0111", {sync_err, locked, slot});
      end
      step(1'b1, 1'b0, 4'h4);
      n_cmp++;
      if (frame_valid !== 1'b1 || {a_out, b_out, c_out, d_out} !== 16'h1234) begin
         n_err++; $display("FAIL timeout_15_frame: fv %b outs %h want 1 1234",
                           frame_valid, {a_out, b_out, c_out, d_out});
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 1; k <= 12; k++) begin
         step(1'b1, ((k % 4) == 1), 4'(k));
         n_cmp++;
         if (frame_valid !== ((k % 4) == 0) || sync_err !== 1'b0) begin
            n_err++; $display("FAIL b2b_fv beat %0d: fv %b err %b want %b 0",
                              k, frame_valid, sync_err, ((k % 4) == 0));
         end
      end
      n_cmp++;
      if ({a_out, b_out, c_out, d_out} !== 16'h9ABC) begin
         n_err++; $display("FAIL b2b_outs: got %h want 9abc", {a_out, b_out, c_out, d_out});
      end
   endtask

   task automatic test_reset_mid_frame();
      step(1'b1, 1'b1, 4'h1);
      step(1'b1, 1'b0, 4'h2);
      rst = 1'b1;
      step(1'b1, 1'b0, 4'h3);
      rst = 1'b0;
      n_cmp++;
      if ({a_out, b_out, c_out, d_out} !== 16'h0000 ||
          {frame_valid, sync_err, locked, slot} !== 5'b0) begin
         n_err++; $display("FAIL midrst_clear: outs %h flags %b want 0000 00000",
                           {a_out, b_out, c_out, d_out}, {frame_valid, sync_err, locked, slot});
      end
      step(1'b1, 1'b0, 4'h4);
      n_cmp++;
      if ({locked, slot, sync_err} !== 4'b0000) begin
         n_err++; $display("FAIL midrst_needs_sync: lock/slot/err got %b want 0000", {locked, slot, sync_err});
      end
      step(1'b1, 1'b1, 4'h5);
      step(1'b1, 1'b0, 4'h6);
      step(1'b1, 1'b0, 4'h7);
      step(1'b1, 1'b0, 4'h8);
      n_cmp++;
      if (frame_valid !== 1'b1 || {a_out, b_out, c_out, d_out} !== 16'h5678) begin
         n_err++; $display("FAIL midrst_next_frame: fv %b outs %h want 1 5678",
                           frame_valid, {a_out, b_out, c_out, d_out});
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_resync();
      test_slot0_no_sync();
      test_hunt_drop();
      test_timeout();
      test_back_to_back();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
